banco_registradores: RTL and testbench
======================================

Name: banco_registradores

Overview:
- ARM-style 16 x 32-bit register bank with two read ports and one write port.
- Sits directly downstream of the 4:1 write-back data selector: the selector's 32-bit output drives DadoEscrita here.
- Read ports feed the ALU operand path.
- R15 is not stored. Reads of R15 return the program counter plus 8, which is the ARM pipeline offset.

Parameters:
- LARGURA, 32, data width in bits.
- NUM_REGS, 16, number of architectural registers. Address width is fixed at 4 bits. Index NUM_REGS-1 is R15.
- OFFSET_PC, 8, value added to PC on R15 reads.

Ports:
- Clock  input  1  single system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- EnderecoLeitura1  input  4  read port 1 register index.
- EnderecoLeitura2  input  4  read port 2 register index.
- EnderecoEscrita  input  4  write port register index.
- DadoEscrita  input  LARGURA  write data (from write-back selector output).
- EscritaHabilitada  input  1  write enable, sampled on rising Clock.
- PC  input  LARGURA  current program counter value.
- DadoLeitura1  output  LARGURA  read port 1 data.
- DadoLeitura2  output  LARGURA  read port 2 data.
- Ocupado  output  1  high while the post-reset clear sequence runs.

Behaviour:
- Storage: 15 registers, R0..R14, each LARGURA bits. R15 has no storage.
- Reset (synchronous):
  - On any rising Clock with Reset=1, all R0..R14 are set to 0 and Ocupado is set to 1.
  - Reset overrides a simultaneous write.
  - Reset asserted mid-operation discards any write in that cycle.
- Ocupado (clear sequence):
  - After Reset deasserts, Ocupado stays 1 for exactly 1 further cycle, then goes 0.
  - It is a 2-state FSM: LIMPANDO -> PRONTO, entered LIMPANDO on reset.
  - Writes presented while Ocupado=1 are ignored.
  - Reset value of Ocupado is 1.
- Write:
  - On rising Clock with Reset=0, Ocupado=0, EscritaHabilitada=1 and EnderecoEscrita != 15, the addressed register takes DadoEscrita.
  - Latency is 1 cycle: the value is visible from storage starting the next cycle.
  - Writes to address 15 are silently dropped. The PC is owned by the fetch stage.
- Read (combinational, zero latency), evaluated for each port independently:
  - Address 15: output = PC + OFFSET_PC, modulo 2^LARGURA (wrap-around, carry discarded).
  - Else, bypass: if EscritaHabilitada=1, Ocupado=0, Reset=0 and the read address equals EnderecoEscrita, output = DadoEscrita (same-cycle forwarding).
  - Otherwise, output = the stored register value.
- Both read ports may address the same register, including the one being written; both return identical values.
- Output values during and right after reset:
  - While Reset=1, both read outputs for addresses 0..14 are 0, and bypass is disabled.
  - Address 15 always reflects PC + OFFSET_PC, including during reset.
- X-free: no path produces X from valid inputs. Unused storage bits do not exist.

Test Plan:
- Reset then read all 0..14 on both ports -> all 0; Ocupado=1 during reset and 1 cycle after, then 0.
- Write R3=0xDEADBEEF (EscritaHabilitada=1, EnderecoEscrita=3), then read port 1 addr 3 and port 2 addr 3 next cycle -> both 0xDEADBEEF. Other registers remain 0.
- Same-cycle bypass: write R7=0x12345678 while EnderecoLeitura1=7 -> DadoLeitura1=0x12345678 in that cycle. Stored old value 0x00000000 must not appear.
- R15 handling:
  - PC=0x00001000, read addr 15 -> 0x00001008.
  - PC=0xFFFFFFFC -> 0x00000004 (wrap).
  - Write to addr 15 with data 0xAAAAAAAA -> reads of 15 unchanged and R0..R14 unaffected.
- Reset collision: Reset=1 and write R5=0x55 in the same cycle -> R5=0 afterwards. Write R5=0x55 on the cycle Ocupado=1 -> ignored, R5=0. Write on the first cycle Ocupado=0 -> R5=0x55 next cycle.
- Back-to-back writes R1=1, R1=2, R2=3 on consecutive cycles, both ports reading 1 and 2 continuously -> port values track with bypass each cycle. Final R1=2, R2=3.

Source files
------------

// File: rtl/banco_registradores_if.sv
// rtl/banco_registradores_if.sv - register bank access bus (read ports, write port, PC, busy)
interface banco_registradores_if #(
  parameter int LARGURA = 32
);
  logic [3:0]         EnderecoLeitura1;
  logic [3:0]         EnderecoLeitura2;
  logic [3:0]         EnderecoEscrita;
  logic [LARGURA-1:0] DadoEscrita;
  logic               EscritaHabilitada;
  logic [LARGURA-1:0] PC;
  logic [LARGURA-1:0] DadoLeitura1;
  logic [LARGURA-1:0] DadoLeitura2;
  logic               Ocupado;

  // Pipeline side: drives addresses, write data and PC; receives operands.
  modport master (
    output EnderecoLeitura1, EnderecoLeitura2, EnderecoEscrita,
    output DadoEscrita, EscritaHabilitada, PC,
    input  DadoLeitura1, DadoLeitura2, Ocupado
  );

  // Register bank side.
  modport slave (
    input  EnderecoLeitura1, EnderecoLeitura2, EnderecoEscrita,
    input  DadoEscrita, EscritaHabilitada, PC,
    output DadoLeitura1, DadoLeitura2, Ocupado
  );
endinterface

// File: rtl/banco_registradores.sv
// rtl/banco_registradores.sv - 16 x 32 ARM-style register bank, R15 reads as PC+8
module banco_registradores #(
  parameter int LARGURA   = 32,
  parameter int NUM_REGS  = 16,
  parameter int OFFSET_PC = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  banco_registradores_if.slave  bus
);

  // R15 is the last architectural index and has no storage behind it.
  localparam logic [3:0] IDX_PC    = 4'(NUM_REGS - 1);
  localparam int         NUM_ARMAZ = NUM_REGS - 1;

  typedef enum logic {
    LIMPANDO = 1'b0,
    PRONTO   = 1'b1
  } estado_t;

  estado_t             estado;
  estado_t             proximo_estado;
  logic                ocupado;

  logic [LARGURA-1:0]  regs [NUM_ARMAZ];

  logic                encaminha_ok;
  logic                escrita_valida;
  logic [LARGURA-1:0]  pc_lido;
  logic [LARGURA-1:0]  armaz1;
  logic [LARGURA-1:0]  armaz2;
  logic [LARGURA-1:0]  leitura1;
  logic [LARGURA-1:0]  leitura2;

  // Clear-sequence state register: reset always re-enters LIMPANDO.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado <= LIMPANDO;
    end else begin
      estado <= proximo_estado;
    end
  end

  // Clear sequence holds the bank busy for one cycle after reset releases.
  always_comb begin
    proximo_estado = estado;
    ocupado        = 1'b0;
    case (estado)
      LIMPANDO: begin
        ocupado        = 1'b1;
        proximo_estado = PRONTO;
      end
      PRONTO: begin
        proximo_estado = PRONTO;
      end
      default: begin
        ocupado        = 1'b1;
        proximo_estado = LIMPANDO;
      end
    endcase
  end

  // A write is live only outside reset and the busy window; forwarding uses
  // the same qualification, and storage additionally drops writes to R15.
  always_comb begin
    encaminha_ok   = bus.EscritaHabilitada && !ocupado && !Reset;
    escrita_valida = encaminha_ok && (bus.EnderecoEscrita != IDX_PC);
    pc_lido        = bus.PC + LARGURA'(OFFSET_PC);
  end

  // Storage for R0..R14: reset clears everything and wins over any write.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < NUM_ARMAZ; i++) begin
      if (Reset) begin
        regs[i] <= '0;
      end else if (escrita_valida && (bus.EnderecoEscrita == 4'(i))) begin
        regs[i] <= bus.DadoEscrita;
      end
    end
  end

  // Stored-value lookup for both ports; an index of 15 selects nothing here.
  always_comb begin
    armaz1 = '0;
    armaz2 = '0;
    for (int i = 0; i < NUM_ARMAZ; i++) begin
      if (bus.EnderecoLeitura1 == 4'(i)) begin
        armaz1 = regs[i];
      end
      if (bus.EnderecoLeitura2 == 4'(i)) begin
        armaz2 = regs[i];
      end
    end
  end

  // Read port 1 priority: PC view, reset zero, same-cycle forward, storage.
  always_comb begin
    leitura1 = armaz1;
    if (bus.EnderecoLeitura1 == IDX_PC) begin
      leitura1 = pc_lido;
    end else if (Reset) begin
      leitura1 = '0;
    end else if (encaminha_ok && (bus.EnderecoLeitura1 == bus.EnderecoEscrita)) begin
      leitura1 = bus.DadoEscrita;
    end
  end

  // Read port 2 priority: identical to port 1, evaluated independently.
  always_comb begin
    leitura2 = armaz2;
    if (bus.EnderecoLeitura2 == IDX_PC) begin
      leitura2 = pc_lido;
    end else if (Reset) begin
      leitura2 = '0;
    end else if (encaminha_ok && (bus.EnderecoLeitura2 == bus.EnderecoEscrita)) begin
      leitura2 = bus.DadoEscrita;
    end
  end

  assign bus.DadoLeitura1 = leitura1;
  assign bus.DadoLeitura2 = leitura2;
  assign bus.Ocupado      = ocupado;

endmodule

// File: tb/tb_banco_registradores.sv
// tb/tb_banco_registradores.sv - randomized self-checking bench for banco_registradores
module tb_banco_registradores;

  logic Clock;
  logic Reset;

  banco_registradores_if #(.LARGURA(32)) bus ();

  banco_registradores #(
    .LARGURA   (32),
    .NUM_REGS  (16),
    .OFFSET_PC (8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total_checks = 0;
  int passed_checks = 0;

  // Reference model: architectural register contents and busy flag.
  logic [31:0] mem [15];
  bit          ocup_m = 1'b0;
  bit          model_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] esperado(input logic [3:0] a);
    if (a == 4'd15) return bus.PC + 32'd8;
    if (Reset) return 32'd0;
    if (bus.EscritaHabilitada && !ocup_m && a == bus.EnderecoEscrita) return bus.DadoEscrita;
    return mem[a];
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 15; i++) mem[i] <= 32'd0;
      ocup_m      <= 1'b1;
      model_valid <= 1'b1;
    end else begin
      if (bus.EscritaHabilitada && !ocup_m && bus.EnderecoEscrita != 4'd15)
        mem[bus.EnderecoEscrita] <= bus.DadoEscrita;
      ocup_m <= 1'b0;
    end
  end

  always @(negedge Clock) begin
    if (model_valid) begin
      check("rd1_model", bus.DadoLeitura1, esperado(bus.EnderecoLeitura1));
      check("rd2_model", bus.DadoLeitura2, esperado(bus.EnderecoLeitura2));
      check("ocupado_model", {31'd0, bus.Ocupado}, {31'd0, ocup_m});
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_in(input bit rst, input bit en, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] r1, input logic [3:0] r2, input logic [31:0] pc);
    Reset                 = rst;
    bus.EscritaHabilitada = en;
    bus.EnderecoEscrita   = wa;
    bus.DadoEscrita       = wd;
    bus.EnderecoLeitura1  = r1;
    bus.EnderecoLeitura2  = r2;
    bus.PC                = pc;
  endtask

  initial begin
    // Reset with a colliding write to R5; scan all addresses while held.
    set_in(1, 1, 4'd5, 32'h55, 4'd0, 4'd14, 32'h0);
    for (int a = 0; a < 15; a++) begin
      set_in(1, 1, 4'd5, 32'h55, 4'(a), 4'(14 - a), 32'h0);
      @(negedge Clock);
      check("reset_rd1_zero", bus.DadoLeitura1, 32'd0);
      check("reset_rd2_zero", bus.DadoLeitura2, 32'd0);
      check("reset_ocupado", {31'd0, bus.Ocupado}, 32'd1);
      tick();
    end

    // Busy cycle: write to R5 must be ignored and not forwarded.
    set_in(0, 1, 4'd5, 32'h55, 4'd5, 4'd5, 32'h0);
    @(negedge Clock);
    check("busy_ocupado", {31'd0, bus.Ocupado}, 32'd1);
    check("busy_no_bypass", bus.DadoLeitura1, 32'd0);
    tick();

    // First ready cycle: write accepted and forwarded.
    @(negedge Clock);
    check("ready_ocupado", {31'd0, bus.Ocupado}, 32'd0);
    check("ready_bypass", bus.DadoLeitura1, 32'h55);
    tick();
    set_in(0, 0, 4'd0, 32'h0, 4'd5, 4'd6, 32'h0);
    @(negedge Clock);
    check("r5_stored", bus.DadoLeitura1, 32'h55);
    check("r6_zero", bus.DadoLeitura2, 32'd0);
    tick();

    // R3 write then read on both ports.
    set_in(0, 1, 4'd3, 32'hDEADBEEF, 4'd4, 4'd2, 32'h0);
    tick();
    set_in(0, 0, 4'd0, 32'h0, 4'd3, 4'd3, 32'h0);
    @(negedge Clock);
    check("r3_port1", bus.DadoLeitura1, 32'hDEADBEEF);
    check("r3_port2", bus.DadoLeitura2, 32'hDEADBEEF);
    tick();

    // Same-cycle forwarding of R7.
    set_in(0, 1, 4'd7, 32'h12345678, 4'd7, 4'd8, 32'h0);
    @(negedge Clock);
    check("r7_bypass", bus.DadoLeitura1, 32'h12345678);
    check("r8_zero", bus.DadoLeitura2, 32'd0);
    tick();

    // R15 views and dropped write to 15.
    set_in(0, 0, 4'd0, 32'h0, 4'd15, 4'd15, 32'h00001000);
    @(negedge Clock);
    check("pc_plus8", bus.DadoLeitura1, 32'h00001008);
    tick();
    set_in(0, 0, 4'd0, 32'h0, 4'd15, 4'd3, 32'hFFFFFFFC);
    @(negedge Clock);
    check("pc_wrap", bus.DadoLeitura1, 32'h00000004);
    tick();
    set_in(0, 1, 4'd15, 32'hAAAAAAAA, 4'd15, 4'd0, 32'h00002000);
    @(negedge Clock);
    check("r15_write_rd15", bus.DadoLeitura1, 32'h00002008);
    check("r15_write_r0", bus.DadoLeitura2, 32'd0);
    tick();
    set_in(0, 0, 4'd0, 32'h0, 4'd15, 4'd14, 32'h00002000);
    @(negedge Clock);
    check("r15_after_rd15", bus.DadoLeitura1, 32'h00002008);
    check("r14_untouched", bus.DadoLeitura2, 32'd0);
    tick();

    // Back-to-back writes with both ports watching R1 and R2.
    set_in(0, 1, 4'd1, 32'd1, 4'd1, 4'd2, 32'h0);
    @(negedge Clock);
    check("b2b_c1_r1", bus.DadoLeitura1, 32'd1);
    check("b2b_c1_r2", bus.DadoLeitura2, 32'd0);
    tick();
    set_in(0, 1, 4'd1, 32'd2, 4'd1, 4'd2, 32'h0);
    @(negedge Clock);
    check("b2b_c2_r1", bus.DadoLeitura1, 32'd2);
    check("b2b_c2_r2", bus.DadoLeitura2, 32'd0);
    tick();
    set_in(0, 1, 4'd2, 32'd3, 4'd1, 4'd2, 32'h0);
    @(negedge Clock);
    check("b2b_c3_r1", bus.DadoLeitura1, 32'd2);
    check("b2b_c3_r2", bus.DadoLeitura2, 32'd3);
    tick();
    set_in(0, 0, 4'd0, 32'h0, 4'd1, 4'd2, 32'h0);
    @(negedge Clock);
    check("b2b_final_r1", bus.DadoLeitura1, 32'd2);
    check("b2b_final_r2", bus.DadoLeitura2, 32'd3);
    tick();

    // Randomized traffic, occasional resets, checked by the model process.
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom_range(0, 59) == 0),
             ($urandom_range(0, 2) != 0),
             4'($urandom_range(0, 15)),
             $urandom(),
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             $urandom());
      tick();
    end

    @(negedge Clock);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
